// File: rtl/onehot_reducer_if.sv
// onehot_reducer_if: seed/start request and valid/ready result bus of onehot_reducer
interface onehot_reducer_if #(parameter int WIDTH = 4, parameter int STEP_W = $clog2(WIDTH));
    logic              start;
    logic [WIDTH-1:0]  din;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  dout;
    logic [STEP_W-1:0] steps;
    logic              err;
    modport master (output start, din, out_ready, input busy, out_valid, dout, steps, err);
    modport slave  (input start, din, out_ready, output busy, out_valid, dout, steps, err);
endinterface

// File: rtl/onehot_reducer.sv
// onehot_reducer: clears the lowest set bit of a seed each cycle until one-hot, then hands it out.
// ONEHOT_REDUCER_ZERO_ERR_EN: zero seed yields err=1/dout=0 instead of being forced to 1.
module onehot_reducer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = $clog2(WIDTH)
) (
    input logic clk,
    input logic rst,
    onehot_reducer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state, state_n;
    logic [WIDTH-1:0]  a, a_n;
    logic [STEP_W-1:0] cnt, cnt_n;
    logic              onehot;
    assign onehot = (a != '0) && ((a & (a - WIDTH'(1))) == '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        a_n     = a;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.start) begin
`ifdef ONEHOT_REDUCER_ZERO_ERR_EN
                a_n = bus.din;
`else
                a_n = (bus.din == '0) ? WIDTH'(1) : bus.din;
`endif
                cnt_n   = '0;
                state_n = RUN;
            end
            RUN: if (onehot || a == '0) state_n = DONE;
            else begin
                a_n   = a & (a - WIDTH'(1));
                cnt_n = cnt + STEP_W'(1);
            end
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign bus.busy      = state != IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.dout      = a;
    assign bus.steps     = cnt;
`ifdef ONEHOT_REDUCER_ZERO_ERR_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (state == RUN && a == '0) err_q <= 1'b1;
        else if (state == DONE && bus.out_ready) err_q <= 1'b0;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_onehot_reducer.sv
// tb_onehot_reducer: directed and randomized checks of onehot_reducer against a popcount/MSB model.
module tb_onehot_reducer;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;
    onehot_reducer_if #(.WIDTH(W)) bus ();
    onehot_reducer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pop(input logic [W-1:0] d);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(d[i]);
        return n;
    endfunction

    function automatic logic [W-1:0] exp_dout(input logic [W-1:0] d);
        logic [W-1:0] r = '0;
`ifdef ONEHOT_REDUCER_ZERO_ERR_EN
        if (d == '0) return '0;
`else
        if (d == '0) return W'(1);
`endif
        for (int i = 0; i < W; i++) if (d[i]) r = W'(1) << i;
        return r;
    endfunction

    function automatic int exp_steps(input logic [W-1:0] d);
        return (d == '0) ? 0 : pop(d) - 1;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] d);
        return (d == '0) ? 2 : pop(d) + 1;
    endfunction

    function automatic logic exp_err(input logic [W-1:0] d);
`ifdef ONEHOT_REDUCER_ZERO_ERR_EN
        return d == '0;
`else
        return 1'b0;
`endif
    endfunction

    // Edge counts are measured from the edge that samples start (edge N = count 0).
    task automatic run_one(input logic [W-1:0] d, input int delay, input bit spam);
        int n;
        bus.din = d;
        bus.start = 1'b1;
        bus.out_ready = (delay == 0);
        tick();
        bus.start = spam;
        if (spam) bus.din = W'(1);
        check("busy_run", 32'(bus.busy), 1);
        n = 1;
        while (!bus.out_valid && n < 3 * W) begin
            tick();
            n++;
        end
        check("latency", n, exp_lat(d));
        check("dout", 32'(bus.dout), 32'(exp_dout(d)));
        check("steps", 32'(bus.steps), exp_steps(d));
        check("err", 32'(bus.err), 32'(exp_err(d)));
        if (!bus.err) check("onehot", 32'($onehot(bus.dout)), 1);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_dout", 32'(bus.dout), 32'(exp_dout(d)));
            check("hold_steps", 32'(bus.steps), exp_steps(d));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        check("valid_fall", 32'(bus.out_valid), 0);
        check("busy_fall", 32'(bus.busy), 0);
        if (spam) for (int i = 0; i < 3; i++) begin
            tick();
            check("no_second", 32'({bus.busy, bus.out_valid}), 0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.din = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_steps", 32'(bus.steps), 0);
        check("rst_err", 32'(bus.err), 0);
        tick();
        rst = 1'b0;
        tick();
        // Reset mid-RUN discards the partial reduction.
        bus.din = 4'b1111;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrun_busy", 32'(bus.busy), 0);
        check("midrun_valid", 32'(bus.out_valid), 0);
        check("midrun_dout", 32'(bus.dout), 0);
        check("midrun_steps", 32'(bus.steps), 0);
        #2 rst = 1'b0;
        tick();
        run_one(4'b0100, 1, 1'b0);
        run_one(4'b1111, 0, 1'b0);
        run_one(4'b1010, 5, 1'b0);
        run_one(4'b0110, 1, 1'b1);
        run_one(4'b0000, 2, 1'b0);
        for (int d = 0; d < 16; d++) run_one(W'(d), int'($urandom_range(0, 3)), 1'b0);
        for (int i = 0; i < 20; i++) run_one(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
